fpu_sp: RTL and testbench



---
 rtl/fpu_pkg.sv | 74 +++++++
 rtl/fpu_sp_if.sv | 25 ++
 rtl/fpu_fma.sv | 125 ++++++++++++
 rtl/fpu_sp.sv | 151 +++++++++++++++
 tb/tb_fpu_sp.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared constants, types and classification helpers for the binary32 FPU.
package fpu_pkg;

  localparam int unsigned FLEN       = 32;
  localparam int unsigned FPU_OP_NUM = 19;

  typedef logic [FPU_OP_NUM-1:0] fpu_op_t;

  localparam fpu_op_t FPU_OP_FADD   = FPU_OP_NUM'(1) << 0;
  localparam fpu_op_t FPU_OP_FSUB   = FPU_OP_NUM'(1) << 1;
  localparam fpu_op_t FPU_OP_FMUL   = FPU_OP_NUM'(1) << 2;
  localparam fpu_op_t FPU_OP_FDIV   = FPU_OP_NUM'(1) << 3;
  localparam fpu_op_t FPU_OP_FSQRT  = FPU_OP_NUM'(1) << 4;
  localparam fpu_op_t FPU_OP_FMADD  = FPU_OP_NUM'(1) << 5;
  localparam fpu_op_t FPU_OP_FMSUB  = FPU_OP_NUM'(1) << 6;
  localparam fpu_op_t FPU_OP_FNMADD = FPU_OP_NUM'(1) << 7;
  localparam fpu_op_t FPU_OP_FNMSUB = FPU_OP_NUM'(1) << 8;
  localparam fpu_op_t FPU_OP_FSGNJ  = FPU_OP_NUM'(1) << 9;
  localparam fpu_op_t FPU_OP_FSGNJN = FPU_OP_NUM'(1) << 10;
  localparam fpu_op_t FPU_OP_FSGNJX = FPU_OP_NUM'(1) << 11;
  localparam fpu_op_t FPU_OP_FMIN   = FPU_OP_NUM'(1) << 12;
  localparam fpu_op_t FPU_OP_FMAX   = FPU_OP_NUM'(1) << 13;
  localparam fpu_op_t FPU_OP_FEQ    = FPU_OP_NUM'(1) << 14;
  localparam fpu_op_t FPU_OP_FLT    = FPU_OP_NUM'(1) << 15;
  localparam fpu_op_t FPU_OP_FLE    = FPU_OP_NUM'(1) << 16;
  localparam fpu_op_t FPU_OP_FCLASS = FPU_OP_NUM'(1) << 17;
  localparam fpu_op_t FPU_OP_FMV    = FPU_OP_NUM'(1) << 18;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam int unsigned FF_NX = 0;
  localparam int unsigned FF_UF = 1;
  localparam int unsigned FF_OF = 2;
  localparam int unsigned FF_DZ = 3;
  localparam int unsigned FF_NV = 4;

  localparam logic [FLEN-1:0] CANON_NAN = 32'h7fc00000;

  typedef struct packed {
    logic [FLEN-1:0] result;
    logic [4:0]      fflags;
  } fpu_resp_t;

  function automatic logic is_nan(input logic [FLEN-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [FLEN-1:0] x);
    return is_nan(x) && !x[22];
  endfunction

  // RISC-V FCLASS mask; subnormals keep their own class here
  function automatic logic [9:0] fp_class(input logic [FLEN-1:0] x);
    logic [9:0] m;
    m = '0;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 23'd0) m[x[31] ? 0 : 7] = 1'b1;
      else if (x[22])       m[9] = 1'b1;
      else                  m[8] = 1'b1;
    end else if (x[30:23] == 8'h00) begin
      if (x[22:0] == 23'd0) m[x[31] ? 3 : 4] = 1'b1;
      else                  m[x[31] ? 2 : 5] = 1'b1;
    end else begin
      m[x[31] ? 1 : 6] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fpu_sp_if.sv
// Request/response bundle between the execute stage and the FPU.
interface fpu_sp_if;
  import fpu_pkg::*;

  logic [3:1][FLEN-1:0] i_rs;
  fpu_op_t              i_op;
  logic [2:0]           i_rm_inst;
  logic [2:0]           i_rm_fcsr;
  logic                 i_in_valid;
  logic                 i_out_ready;
  logic                 o_in_ready;
  logic [FLEN-1:0]      o_result;
  logic [4:0]           o_fflags;
  logic                 o_out_valid;

  modport slave (
    input  i_rs, i_op, i_rm_inst, i_rm_fcsr, i_in_valid, i_out_ready,
    output o_in_ready, o_result, o_fflags, o_out_valid
  );

  modport master (
    output i_rs, i_op, i_rm_inst, i_rm_fcsr, i_in_valid, i_out_ready,
    input  o_in_ready, o_result, o_fflags, o_out_valid
  );
endinterface

// File: rtl/fpu_fma.sv
// Fused multiply-add datapath: +/-(a*b) + c with one final rounding, FTZ/DAZ.
module fpu_fma
  import fpu_pkg::*;
(
  input  logic [FLEN-1:0] a_i,
  input  logic [FLEN-1:0] b_i,
  input  logic [FLEN-1:0] c_i,
  input  logic            neg_p_i,
  input  logic [2:0]      rm_i,
  output logic [FLEN-1:0] res_o,
  output logic [4:0]      flags_o
);

  localparam int unsigned WW = 76;
  localparam int unsigned EW = 12;
  typedef logic signed [EW-1:0] exp_t;

  // Right shift that jams every shifted-out bit into the lsb
  function automatic logic [WW-1:0] shr_jam(input logic [WW-1:0] x, input exp_t d);
    logic [WW-1:0] mask;
    if (d <= 0) return x;
    if (d >= exp_t'(WW)) return {{(WW-1){1'b0}}, |x};
    mask = ~({WW{1'b1}} << d[6:0]);
    return (x >> d[6:0]) | {{(WW-1){1'b0}}, |(x & mask)};
  endfunction

  logic a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, p_zero;
  logic sp, sc, rs, inc, rnd_up, to_max;
  logic [47:0]   prod;
  logic [WW-1:0] pa, ca, sum, norm;
  logic [6:0]    lead;
  logic [24:0]   mr;
  exp_t          ep, ec, emax, e;

  assign a_zero = (a_i[30:23] == 8'h00);
  assign b_zero = (b_i[30:23] == 8'h00);
  assign c_zero = (c_i[30:23] == 8'h00);
  assign a_inf  = (a_i[30:0] == 31'h7f800000);
  assign b_inf  = (b_i[30:0] == 31'h7f800000);
  assign c_inf  = (c_i[30:0] == 31'h7f800000);
  assign p_zero = a_zero | b_zero;
  assign sp     = a_i[31] ^ b_i[31] ^ neg_p_i;
  assign sc     = c_i[31];
  assign prod   = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
  assign ep     = exp_t'({4'b0, a_i[30:23]}) + exp_t'({4'b0, b_i[30:23]}) - exp_t'(127);
  assign ec     = exp_t'({4'b0, c_i[30:23]});

  always_comb begin
    res_o   = '0;
    flags_o = '0;
    emax    = '0;
    pa      = '0;
    ca      = '0;
    sum     = '0;
    norm    = '0;
    lead    = '0;
    e       = '0;
    mr      = '0;
    rs      = sp;
    inc     = 1'b0;
    rnd_up  = 1'b0;
    to_max  = 1'b0;

    if (is_nan(a_i) || is_nan(b_i) || is_nan(c_i)) begin
      res_o          = CANON_NAN;
      flags_o[FF_NV] = is_snan(a_i) | is_snan(b_i) | is_snan(c_i) |
                       (a_inf & b_zero) | (b_inf & a_zero);
    end else if ((a_inf & b_zero) | (b_inf & a_zero) |
                 ((a_inf | b_inf) & c_inf & (sp ^ sc))) begin
      res_o          = CANON_NAN;
      flags_o[FF_NV] = 1'b1;
    end else if (a_inf | b_inf) begin
      res_o = {sp, 8'hFF, 23'd0};
    end else if (c_inf) begin
      res_o = {sc, 8'hFF, 23'd0};
    end else begin
      // Product 1.0 and addend 1.0 both land on bit 73 before alignment
      if (p_zero)      emax = ec;
      else if (c_zero) emax = ep;
      else             emax = (ep > ec) ? ep : ec;
      pa = p_zero ? '0 : shr_jam({1'b0, prod, 27'd0}, emax - ep);
      ca = c_zero ? '0 : shr_jam({2'b0, 1'b1, c_i[22:0], 50'd0}, emax - ec);

      if (!(sp ^ sc))   begin sum = pa + ca; rs = sp; end
      else if (pa >= ca) begin sum = pa - ca; rs = sp; end
      else               begin sum = ca - pa; rs = sc; end

      if (sum == '0) begin
        if (p_zero && c_zero) rs = (sp & sc) | ((rm_i == RM_RDN) & (sp | sc));
        else                  rs = (rm_i == RM_RDN);
        res_o = {rs, 31'd0};
      end else begin
        for (int i = 0; i < int'(WW); i++) if (sum[i]) lead = 7'(i);
        norm = sum << (7'(WW - 1) - lead);
        e    = emax + exp_t'({5'b0, lead}) - exp_t'(73);

        case (rm_i)
          RM_RTZ:  inc = 1'b0;
          RM_RDN:  inc = rs & (norm[51] | (|norm[50:0]));
          RM_RUP:  inc = !rs & (norm[51] | (|norm[50:0]));
          RM_RMM:  inc = norm[51];
          default: inc = norm[51] & ((|norm[50:0]) | norm[52]);
        endcase
        mr = {1'b0, norm[75:52]} + 25'(inc);
        if (mr[24]) e = e + exp_t'(1);

        if (e >= exp_t'(255)) begin
          to_max  = (rm_i == RM_RTZ) || ((rm_i == RM_RDN) && !rs) || ((rm_i == RM_RUP) && rs);
          res_o   = to_max ? {rs, 8'hFE, 23'h7FFFFF} : {rs, 8'hFF, 23'd0};
          flags_o[FF_OF] = 1'b1;
          flags_o[FF_NX] = 1'b1;
        end else if (e <= exp_t'(0)) begin
          res_o   = {rs, 31'd0};
          flags_o[FF_UF] = 1'b1;
          flags_o[FF_NX] = 1'b1;
        end else begin
          res_o   = {rs, e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
          rnd_up  = norm[51] | (|norm[50:0]);
          flags_o[FF_NX] = rnd_up;
        end
      end
    end
  end

endmodule

// File: rtl/fpu_sp.sv
// Single-precision RISC-V F-extension FPU top: decode, non-arithmetic ops, result mux.
// Optional output register stage enabled by defining FPU_OUT_REG_EN.
module fpu_sp
  import fpu_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  fpu_sp_if.slave  bus
);

  localparam logic [FLEN-1:0] FP_ONE    = 32'h3f800000;
  localparam logic [FLEN-1:0] FP_NEG_Z  = 32'h80000000;

  logic [FLEN-1:0] rs1, rs2, rs3, fa, fb, fc, fma_res;
  logic [4:0]      fma_flags;
  logic [2:0]      rm_eff;
  fpu_op_t         sel;
  logic            neg_p, a_nan, b_nan, any_snan, both_zero, lt, lt_tot, eq;
  fpu_resp_t       resp_c;

  assign rs1    = bus.i_rs[1];
  assign rs2    = bus.i_rs[2];
  assign rs3    = bus.i_rs[3];
  assign rm_eff = (bus.i_rm_inst == RM_DYN) ? bus.i_rm_fcsr : bus.i_rm_inst;
  // Isolate the lowest set bit so a malformed op vector still decodes to one op
  assign sel    = bus.i_op & (~bus.i_op + FPU_OP_NUM'(1));

  always_comb begin
    fa    = rs1;
    fb    = rs2;
    fc    = rs3;
    neg_p = 1'b0;
    case (sel)
      FPU_OP_FADD:   begin fb = FP_ONE; fc = rs2; end
      FPU_OP_FSUB:   begin fb = FP_ONE; fc = {~rs2[31], rs2[30:0]}; end
      FPU_OP_FMUL:   fc = FP_NEG_Z;
      FPU_OP_FMSUB:  fc = {~rs3[31], rs3[30:0]};
      FPU_OP_FNMADD: begin neg_p = 1'b1; fc = {~rs3[31], rs3[30:0]}; end
      FPU_OP_FNMSUB: neg_p = 1'b1;
      default: ;
    endcase
  end

  fpu_fma u_fma (
    .a_i     (fa),
    .b_i     (fb),
    .c_i     (fc),
    .neg_p_i (neg_p),
    .rm_i    (rm_eff),
    .res_o   (fma_res),
    .flags_o (fma_flags)
  );

  assign a_nan     = is_nan(rs1);
  assign b_nan     = is_nan(rs2);
  assign any_snan  = is_snan(rs1) | is_snan(rs2);
  assign both_zero = (rs1[30:0] == 31'd0) && (rs2[30:0] == 31'd0);
  assign eq        = (rs1 == rs2) || both_zero;

  // lt treats +/-0 as equal; lt_tot orders -0 below +0 for min/max
  always_comb begin
    if (rs1[31] != rs2[31]) begin
      lt     = rs1[31] && !both_zero;
      lt_tot = rs1[31];
    end else begin
      lt     = rs1[31] ? (rs1[30:0] > rs2[30:0]) : (rs1[30:0] < rs2[30:0]);
      lt_tot = lt;
    end
  end

  always_comb begin
    resp_c = '0;
    case (sel)
      FPU_OP_FADD, FPU_OP_FSUB, FPU_OP_FMUL, FPU_OP_FMADD,
      FPU_OP_FMSUB, FPU_OP_FNMADD, FPU_OP_FNMSUB: begin
        resp_c.result = fma_res;
        resp_c.fflags = fma_flags;
      end
      FPU_OP_FDIV, FPU_OP_FSQRT: begin
        resp_c.result        = CANON_NAN;
        resp_c.fflags[FF_NV] = 1'b1;
      end
      FPU_OP_FSGNJ:  resp_c.result = {rs2[31], rs1[30:0]};
      FPU_OP_FSGNJN: resp_c.result = {~rs2[31], rs1[30:0]};
      FPU_OP_FSGNJX: resp_c.result = {rs1[31] ^ rs2[31], rs1[30:0]};
      FPU_OP_FMIN, FPU_OP_FMAX: begin
        if (a_nan && b_nan) resp_c.result = CANON_NAN;
        else if (a_nan)     resp_c.result = rs2;
        else if (b_nan)     resp_c.result = rs1;
        else                resp_c.result = (lt_tot ^ (sel == FPU_OP_FMAX)) ? rs1 : rs2;
        resp_c.fflags[FF_NV] = any_snan;
      end
      FPU_OP_FEQ: begin
        resp_c.result        = {31'd0, !(a_nan | b_nan) && eq};
        resp_c.fflags[FF_NV] = any_snan;
      end
      FPU_OP_FLT: begin
        resp_c.result        = {31'd0, !(a_nan | b_nan) && lt};
        resp_c.fflags[FF_NV] = a_nan | b_nan;
      end
      FPU_OP_FLE: begin
        resp_c.result        = {31'd0, !(a_nan | b_nan) && (lt || eq)};
        resp_c.fflags[FF_NV] = a_nan | b_nan;
      end
      FPU_OP_FCLASS: resp_c.result = {22'd0, fp_class(rs1)};
      FPU_OP_FMV:    resp_c.result = rs1;
      default: ;
    endcase
  end

`ifdef FPU_OUT_REG_EN
  fpu_resp_t resp_d, resp_q;
  logic      valid_d, valid_q, in_ready_c;

  assign in_ready_c = !valid_q || bus.i_out_ready;

  always_comb begin
    resp_d  = resp_q;
    valid_d = valid_q;
    if (bus.i_in_valid && in_ready_c) begin
      resp_d  = resp_c;
      valid_d = 1'b1;
    end else if (bus.i_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      resp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      resp_q  <= resp_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_result    = resp_q.result;
  assign bus.o_fflags    = resp_q.fflags;
  assign bus.o_out_valid = valid_q;
  assign bus.o_in_ready  = in_ready_c;
`else
  logic unused_clk_rst;
  assign unused_clk_rst  = i_clk ^ i_rst;
  assign bus.o_result    = resp_c.result;
  assign bus.o_fflags    = resp_c.fflags;
  assign bus.o_out_valid = bus.i_in_valid;
  assign bus.o_in_ready  = bus.i_out_ready;
`endif

endmodule

// File: tb/tb_fpu_sp.sv
// Directed-vector bench for fpu_sp; covers both the combinational and FPU_OUT_REG_EN builds.
module tb_fpu_sp;
  import fpu_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fpu_sp_if bus_if ();

  fpu_sp u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic run_op(input fpu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [2:0] rmi);
    @(negedge clk);
    bus_if.i_op        = op;
    bus_if.i_rs[1]     = a;
    bus_if.i_rs[2]     = b;
    bus_if.i_rs[3]     = c;
    bus_if.i_rm_inst   = rmi;
    bus_if.i_in_valid  = 1'b1;
    bus_if.i_out_ready = 1'b1;
`ifdef FPU_OUT_REG_EN
    @(posedge clk);
    #1;
    bus_if.i_in_valid = 1'b0;
`else
    #1;
`endif
  endtask

  task automatic t_op(input string tag, input fpu_op_t op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic [2:0] rmi,
                      input logic [31:0] exp_res, input logic [4:0] exp_ff, input bit chk_ff);
    run_op(op, a, b, c, rmi);
    check({tag, "_res"}, bus_if.o_result, exp_res);
    if (chk_ff) check({tag, "_ff"}, 32'(bus_if.o_fflags), 32'(exp_ff));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    rst     = 1'b1;
    bus_if.i_op        = '0;
    bus_if.i_rs        = '0;
    bus_if.i_rm_inst   = RM_RNE;
    bus_if.i_rm_fcsr   = RM_RNE;
    bus_if.i_in_valid  = 1'b0;
    bus_if.i_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", bus_if.o_result, 32'h0);
    check("rst_ff", 32'(bus_if.o_fflags), 32'h0);
    check("rst_valid", 32'(bus_if.o_out_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    t_op("fadd_a", FPU_OP_FADD, 32'h3f800000, 32'h40200000, 32'h0, RM_RNE, 32'h40600000, 5'h00, 1);
    check("fadd_a_valid", 32'(bus_if.o_out_valid), 32'h1);
    t_op("fadd_nx", FPU_OP_FADD, 32'h40490fdb, 32'h322bcc77, 32'h0, RM_RNE, 32'h40490fdb, 5'h01, 1);
    t_op("fsub_a", FPU_OP_FSUB, 32'hc49a6333, 32'hbf8ccccd, 32'h0, RM_RNE, 32'hc49a4000, 5'h00, 0);
    t_op("fsub_b", FPU_OP_FSUB, 32'h40200000, 32'h3f800000, 32'h0, RM_RNE, 32'h3fc00000, 5'h00, 1);
    t_op("fmul_a", FPU_OP_FMUL, 32'hc49a6333, 32'hbf8ccccd, 32'h0, RM_RNE, 32'h44a9d385, 5'h01, 1);
    t_op("fmul_b", FPU_OP_FMUL, 32'h40490fdb, 32'h322bcc77, 32'h0, RM_RNE, 32'h3306ee2d, 5'h00, 0);
    t_op("fmadd_a", FPU_OP_FMADD, 32'h40000000, 32'hc0a00000, 32'hc0000000, RM_RNE, 32'hc1400000, 5'h00, 1);
    t_op("fmadd_b", FPU_OP_FMADD, 32'hc49a6333, 32'hbf800000, 32'h3f8ccccd, RM_RNE, 32'h449a8666, 5'h00, 0);
    t_op("fmsub", FPU_OP_FMSUB, 32'h40000000, 32'hc0a00000, 32'hc0000000, RM_RNE, 32'hc1000000, 5'h00, 1);
    t_op("fnmadd", FPU_OP_FNMADD, 32'h40000000, 32'hc0a00000, 32'hc0000000, RM_RNE, 32'h41400000, 5'h00, 1);
    t_op("fnmsub", FPU_OP_FNMSUB, 32'h40000000, 32'hc0a00000, 32'hc0000000, RM_RNE, 32'h41000000, 5'h00, 1);
    t_op("inf_x_0", FPU_OP_FMUL, 32'h7f800000, 32'h00000000, 32'h0, RM_RNE, 32'h7fc00000, 5'h10, 1);
    t_op("inf_m_inf", FPU_OP_FSUB, 32'h7f800000, 32'h7f800000, 32'h0, RM_RNE, 32'h7fc00000, 5'h10, 1);
    t_op("ovf_rne", FPU_OP_FADD, 32'h7f7fffff, 32'h7f7fffff, 32'h0, RM_RNE, 32'h7f800000, 5'h05, 1);
    t_op("ovf_rtz", FPU_OP_FADD, 32'h7f7fffff, 32'h7f7fffff, 32'h0, RM_RTZ, 32'h7f7fffff, 5'h05, 1);
    bus_if.i_rm_fcsr = RM_RTZ;
    t_op("ovf_dyn", FPU_OP_FADD, 32'h7f7fffff, 32'h7f7fffff, 32'h0, RM_DYN, 32'h7f7fffff, 5'h05, 1);
    bus_if.i_rm_fcsr = RM_RNE;
    t_op("unf", FPU_OP_FMUL, 32'h00800000, 32'h3f000000, 32'h0, RM_RNE, 32'h00000000, 5'h03, 1);
    t_op("zero_rne", FPU_OP_FSUB, 32'h3f800000, 32'h3f800000, 32'h0, RM_RNE, 32'h00000000, 5'h00, 1);
    t_op("zero_rdn", FPU_OP_FSUB, 32'h3f800000, 32'h3f800000, 32'h0, RM_RDN, 32'h80000000, 5'h00, 1);
    t_op("fmul_negz", FPU_OP_FMUL, 32'h80000000, 32'h3f800000, 32'h0, RM_RNE, 32'h80000000, 5'h00, 1);
    t_op("fdiv", FPU_OP_FDIV, 32'h3f800000, 32'h40000000, 32'h0, RM_RNE, 32'h7fc00000, 5'h10, 1);
    t_op("fsqrt", FPU_OP_FSQRT, 32'h40800000, 32'h0, 32'h0, RM_RNE, 32'h7fc00000, 5'h10, 1);
    t_op("fsgnj", FPU_OP_FSGNJ, 32'h3f800000, 32'h80000000, 32'h0, RM_RNE, 32'hbf800000, 5'h00, 1);
    t_op("fsgnjn", FPU_OP_FSGNJN, 32'h3f800000, 32'h80000000, 32'h0, RM_RNE, 32'h3f800000, 5'h00, 1);
    t_op("fsgnjx", FPU_OP_FSGNJX, 32'hbf800000, 32'h80000000, 32'h0, RM_RNE, 32'h3f800000, 5'h00, 1);
    t_op("fmin_z", FPU_OP_FMIN, 32'h00000000, 32'h80000000, 32'h0, RM_RNE, 32'h80000000, 5'h00, 1);
    t_op("fmax_z", FPU_OP_FMAX, 32'h80000000, 32'h00000000, 32'h0, RM_RNE, 32'h00000000, 5'h00, 1);
    t_op("fmin_qnan", FPU_OP_FMIN, 32'h7fc00000, 32'h3f800000, 32'h0, RM_RNE, 32'h3f800000, 5'h00, 1);
    t_op("fmax_snan", FPU_OP_FMAX, 32'h3f800000, 32'h7f800001, 32'h0, RM_RNE, 32'h3f800000, 5'h10, 1);
    t_op("fmin_2nan", FPU_OP_FMIN, 32'h7fc00001, 32'hff800001, 32'h0, RM_RNE, 32'h7fc00000, 5'h10, 1);
    t_op("feq_z", FPU_OP_FEQ, 32'h00000000, 32'h80000000, 32'h0, RM_RNE, 32'h1, 5'h00, 1);
    t_op("feq_qnan", FPU_OP_FEQ, 32'h7fc00000, 32'h3f800000, 32'h0, RM_RNE, 32'h0, 5'h00, 1);
    t_op("flt", FPU_OP_FLT, 32'hc0000000, 32'h3f800000, 32'h0, RM_RNE, 32'h1, 5'h00, 1);
    t_op("flt_neg", FPU_OP_FLT, 32'hbf800000, 32'hc0000000, 32'h0, RM_RNE, 32'h0, 5'h00, 1);
    t_op("fle_qnan", FPU_OP_FLE, 32'h3f800000, 32'h7fc00000, 32'h0, RM_RNE, 32'h0, 5'h10, 1);
    t_op("fle_eq", FPU_OP_FLE, 32'h40000000, 32'h40000000, 32'h0, RM_RNE, 32'h1, 5'h00, 1);
    t_op("fclass_pn", FPU_OP_FCLASS, 32'h3f800000, 32'h0, 32'h0, RM_RNE, 32'h040, 5'h00, 1);
    t_op("fclass_ninf", FPU_OP_FCLASS, 32'hff800000, 32'h0, 32'h0, RM_RNE, 32'h001, 5'h00, 0);
    t_op("fclass_qnan", FPU_OP_FCLASS, 32'h7fc00000, 32'h0, 32'h0, RM_RNE, 32'h200, 5'h00, 0);
    t_op("fclass_snan", FPU_OP_FCLASS, 32'h7f800001, 32'h0, 32'h0, RM_RNE, 32'h100, 5'h00, 0);
    t_op("fclass_psub", FPU_OP_FCLASS, 32'h00000001, 32'h0, 32'h0, RM_RNE, 32'h020, 5'h00, 0);
    t_op("fclass_nz", FPU_OP_FCLASS, 32'h80000000, 32'h0, 32'h0, RM_RNE, 32'h008, 5'h00, 0);
    t_op("fmv", FPU_OP_FMV, 32'h7f800001, 32'h0, 32'h0, RM_RNE, 32'h7f800001, 5'h00, 1);
    t_op("op_none", '0, 32'h3f800000, 32'h40200000, 32'h0, RM_RNE, 32'h0, 5'h00, 1);
    t_op("op_prio", FPU_OP_FADD | FPU_OP_FMV, 32'h3f800000, 32'h40200000, 32'h0, RM_RNE,
         32'h40600000, 5'h00, 1);

`ifdef FPU_OUT_REG_EN
    // Back-pressure: second request must stall while the first result is held
    @(negedge clk);
    bus_if.i_out_ready = 1'b0;
    bus_if.i_op        = FPU_OP_FADD;
    bus_if.i_rs[1]     = 32'h3f800000;
    bus_if.i_rs[2]     = 32'h40200000;
    bus_if.i_rm_inst   = RM_RNE;
    bus_if.i_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.i_op    = FPU_OP_FSUB;
    bus_if.i_rs[1] = 32'h40200000;
    bus_if.i_rs[2] = 32'h3f800000;
    #1;
    check("hold_in_ready", 32'(bus_if.o_in_ready), 32'h0);
    check("hold_valid", 32'(bus_if.o_out_valid), 32'h1);
    @(posedge clk);
    #1;
    check("hold_res", bus_if.o_result, 32'h40600000);
    check("hold_valid2", 32'(bus_if.o_out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bus_if.o_out_valid), 32'h0);
    check("rst_mid_res", bus_if.o_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_if.i_in_valid  = 1'b0;
    bus_if.i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(bus_if.o_out_valid), 32'h0);
`else
    @(negedge clk);
    bus_if.i_out_ready = 1'b0;
    bus_if.i_in_valid  = 1'b0;
    #1;
    check("comb_in_ready", 32'(bus_if.o_in_ready), 32'h0);
    check("comb_valid", 32'(bus_if.o_out_valid), 32'h0);
    bus_if.i_op    = FPU_OP_FSUB;
    bus_if.i_rs[1] = 32'h40200000;
    bus_if.i_rs[2] = 32'h3f800000;
    rst = 1'b1;
    #1;
    check("comb_rst_res", bus_if.o_result, 32'h3fc00000);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
